// File: rtl/despachador_trabajos_pkg.sv
// Shared types and constants for the job dispatcher.
package despachador_pkg;

  // Default job code width; code NO_JOB means "nothing to do".
  localparam int JOB_W_DEF = 6;
  localparam int NO_JOB    = 0;

  // Per-unit booking state.
  typedef enum logic [1:0] {
    FREE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    RUN       = 2'd3
  } unit_state_e;

endpackage

// File: rtl/despachador_trabajos_cola.sv
// Job buffer: synchronous FIFO, no bypass, power-of-two depth.
module cola_trabajos #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign full_o  = (r_cnt == CW'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign count_o = r_cnt;
  assign data_o  = r_mem[r_rd];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/despachador_trabajos.sv
// Job dispatcher: round-robin intake from requesters into a FIFO, then
// one job per cycle to the lowest-index free work unit, with a per-unit
// tracker so a unit is never handed a second job while still booked.
module despachador_trabajos
  import despachador_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int NUM_UNITS  = 2,
  parameter int JOB_W      = JOB_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*JOB_W-1:0]          req_job_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [NUM_UNITS*JOB_W-1:0]        unit_job_o,
  input  logic [NUM_UNITS-1:0]              unit_busy_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
  output logic                              idle_o,
  output logic                              err_o
);

  localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [RRW-1:0]       r_rr;
  logic                 r_err;
  logic [NUM_REQ-1:0]   w_grant;
  logic [RRW-1:0]       w_gidx;
  logic                 w_found;
  int                   w_cand;
  logic                 w_acc;
  logic [JOB_W-1:0]     w_acc_job;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [JOB_W-1:0]     w_head;
  logic [CW-1:0]        w_count;
  logic [NUM_UNITS-1:0] w_sel;
  logic                 w_sel_any;
  logic [NUM_UNITS-1:0] w_is_free;
  logic [NUM_UNITS-1:0] w_unit_err;

  // Round-robin arbiter: first valid requester at or after r_rr wins,
  // but only while the buffer has room (and never while in reset).
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_cand  = 0;
    if (rst_ni && !w_full) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_cand = (int'(r_rr) + i) % NUM_REQ;
        if (!w_found && req_valid_i[w_cand]) begin
          w_found         = 1'b1;
          w_gidx          = RRW'(w_cand);
          w_grant[w_cand] = 1'b1;
        end
      end
    end
  end

  assign req_ready_o = w_grant;
  assign w_acc       = w_found;
  assign w_acc_job   = req_job_i[w_gidx*JOB_W +: JOB_W];
  // A zero code is handshaken away but never buffered.
  assign w_push      = w_acc && (w_acc_job != JOB_W'(NO_JOB));

  // Fairness pointer: move past the grantee on every acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else if (w_acc) begin
      r_rr <= (w_gidx == RRW'(NUM_REQ - 1)) ? '0 : w_gidx + RRW'(1);
    end
  end

  cola_trabajos #(
    .WIDTH (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cola (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_acc_job),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign fifo_count_o = w_count;

  // Pick the lowest-index unit that is both unbooked and not reporting
  // busy; the busy check covers units still running across a reset.
  always_comb begin
    w_sel     = '0;
    w_sel_any = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!w_sel_any && w_is_free[k] && !unit_busy_i[k]) begin
        w_sel[k]  = 1'b1;
        w_sel_any = 1'b1;
      end
    end
  end

  assign w_pop = w_sel_any && !w_empty;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
    unit_state_e      r_state;
    logic [JOB_W-1:0] r_job;

    assign w_is_free[k]                 = (r_state == FREE);
    assign w_unit_err[k]                = (r_state == WAIT_BUSY) && !unit_busy_i[k];
    assign unit_job_o[k*JOB_W +: JOB_W] = r_job;

    // Tracker: one-cycle job pulse, one cycle to see busy, then hold
    // the unit until busy drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= FREE;
        r_job   <= '0;
      end else begin
        case (r_state)
          FREE: begin
            if (w_sel[k] && w_pop) begin
              r_state <= ISSUE;
              r_job   <= w_head;
            end
          end
          ISSUE: begin
            r_state <= WAIT_BUSY;
            r_job   <= '0;
          end
          WAIT_BUSY: r_state <= unit_busy_i[k] ? RUN : FREE;
          RUN:       if (!unit_busy_i[k]) r_state <= FREE;
          default:   r_state <= FREE;
        endcase
      end
    end
  end

  // Registered error: any unit that never acknowledged its job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err <= 1'b0;
    else         r_err <= |w_unit_err;
  end

  assign err_o  = r_err;
  assign idle_o = w_empty && (&w_is_free) && !(|unit_busy_i);

endmodule

// File: tb/tb_despachador_trabajos.sv
// Bench for despachador_trabajos: queue-based model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_despachador_trabajos;
  localparam int NR = 2;
  localparam int NU = 2;
  localparam int JW = 6;
  localparam int FD = 4;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*JW-1:0] req_job = '0;
  logic [NR-1:0]    req_ready;
  logic [NU*JW-1:0] unit_job;
  logic [NU-1:0]    unit_busy;
  logic [CW-1:0]    fifo_count;
  logic             idle;
  logic             err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  despachador_trabajos #(
    .NUM_REQ(NR), .NUM_UNITS(NU), .JOB_W(JW), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_job_i    (req_job),
    .req_ready_o  (req_ready),
    .unit_job_o   (unit_job),
    .unit_busy_i  (unit_busy),
    .fifo_count_o (fifo_count),
    .idle_o       (idle),
    .err_o        (err)
  );

  // Work-unit models: 4 busy cycles after seeing a job; hold forces busy,
  // nobusy makes the unit ignore jobs. Units have no reset.
  int            u_cnt [NU];
  logic [NU-1:0] hold = '0;
  logic [NU-1:0] nobusy = '0;

  always @(posedge clk) begin
    for (int k = 0; k < NU; k++) begin
      if (unit_job[k*JW +: JW] != '0 && !nobusy[k]) u_cnt[k] <= 4;
      else if (u_cnt[k] > 0)                        u_cnt[k] <= u_cnt[k] - 1;
    end
  end

  always_comb begin
    unit_busy = hold;
    for (int k = 0; k < NU; k++) if (u_cnt[k] != 0) unit_busy[k] = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Requester feeders: each holds its head job until accepted.
  int            fq0[$];
  int            fq1[$];
  logic [NR-1:0] acc_seen = '0;

  task automatic drive();
    req_valid[0]    = (fq0.size() > 0);
    req_valid[1]    = (fq1.size() > 0);
    req_job[0+:JW]  = (fq0.size() > 0) ? JW'(fq0[0]) : '0;
    req_job[JW+:JW] = (fq1.size() > 0) ? JW'(fq1[0]) : '0;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (acc_seen[0] && fq0.size() > 0) void'(fq0.pop_front());
      if (acc_seen[1] && fq1.size() > 0) void'(fq1.pop_front());
      drive();
      #1;
    end
  endtask

  task automatic wait_idle(input int lim);
    int i;
    i = 0;
    while (!idle && i < lim) begin
      step(1);
      i++;
    end
    chk("wait_idle_bound", {31'd0, idle}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Reference model: job list, rr pointer, and per-unit booking ages
  // (age 1 = issue cycle, 2 = busy-check cycle, 3 = running).
  int mq[$];
  int m_rr = 0;
  bit m_own [NU];
  int m_age [NU];
  int m_job [NU];
  bit m_err = 1'b0;

  initial begin : model
    int               g, d, r;
    bit               nerr, own_any;
    logic [NR-1:0]    e_rdy;
    logic [NU*JW-1:0] e_job;
    forever begin
      @(negedge clk);
      acc_seen = req_valid & req_ready;
      if (!rst_n) begin
        mq.delete();
        m_rr  = 0;
        m_err = 1'b0;
        for (int k = 0; k < NU; k++) m_own[k] = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_unit_job", 32'(unit_job), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_idle", {31'd0, idle}, {31'd0, unit_busy == '0});
      end else begin
        g = -1;
        e_rdy = '0;
        if (mq.size() < FD)
          for (int i = 0; i < NR; i++) begin
            r = (m_rr + i) % NR;
            if (g < 0 && req_valid[r]) g = r;
          end
        if (g >= 0) e_rdy[g] = 1'b1;
        e_job = '0;
        own_any = 1'b0;
        for (int k = 0; k < NU; k++) begin
          if (m_own[k]) own_any = 1'b1;
          if (m_own[k] && m_age[k] == 1) e_job[k*JW +: JW] = JW'(m_job[k]);
        end
        chk("ready", 32'(req_ready), 32'(e_rdy));
        chk("unit_job", 32'(unit_job), 32'(e_job));
        chk("count", 32'(fifo_count), 32'(mq.size()));
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("idle", {31'd0, idle}, {31'd0, mq.size() == 0 && !own_any && unit_busy == '0});
        // advance the model to the next cycle
        d = -1;
        if (mq.size() > 0)
          for (int k = 0; k < NU; k++)
            if (d < 0 && !m_own[k] && !unit_busy[k]) d = k;
        nerr = 1'b0;
        for (int k = 0; k < NU; k++) begin
          if (m_own[k]) begin
            if (m_age[k] == 1) m_age[k] = 2;
            else if (!unit_busy[k]) begin
              m_own[k] = 1'b0;
              if (m_age[k] == 2) nerr = 1'b1;
            end else m_age[k] = 3;
          end
        end
        if (d >= 0) begin
          m_own[d] = 1'b1;
          m_age[d] = 1;
          m_job[d] = mq.pop_front();
        end
        if (g >= 0) begin
          if (req_job[g*JW +: JW] != '0) mq.push_back(int'(req_job[g*JW +: JW]));
          m_rr = (g + 1) % NR;
        end
        m_err = nerr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    drive();
    step(2);
    // reset state
    chk("lit_rst_ready", 32'(req_ready), 32'd0);
    chk("lit_rst_job", 32'(unit_job), 32'd0);
    chk("lit_rst_count", 32'(fifo_count), 32'd0);
    chk("lit_rst_idle", {31'd0, idle}, 32'd1);
    rst_n = 1'b1;
    step(1);

    // single job, 4-cycle unit
    fq0.push_back('h2A);
    step(1);
    chk("single_ready", 32'(req_ready), 32'h1);
    step(2);
    chk("single_issue", 32'(unit_job), 32'h02A);
    step(1);
    chk("single_pulse_end", 32'(unit_job), 32'h0);
    step(4);
    chk("single_not_idle", {31'd0, idle}, 32'd0);
    step(1);
    chk("single_idle", {31'd0, idle}, 32'd1);

    // fairness
    do_reset();
    fq0.push_back('h01); fq0.push_back('h01);
    fq1.push_back('h02); fq1.push_back('h02);
    step(1);
    chk("fair_g0", 32'(req_ready), 32'h1);
    step(1);
    chk("fair_g1", 32'(req_ready), 32'h2);
    step(1);
    chk("fair_g2", 32'(req_ready), 32'h1);
    chk("fair_u0", 32'(unit_job), 32'h001);
    step(1);
    chk("fair_g3", 32'(req_ready), 32'h2);
    chk("fair_u1", 32'(unit_job), 32'h080);
    wait_idle(80);

    // full FIFO
    do_reset();
    hold = 2'b11;
    for (int j = 0; j < 5; j++) fq0.push_back('h11 + j);
    step(1);
    chk("full_first", 32'(req_ready), 32'h1);
    step(4);
    chk("full_count4", 32'(fifo_count), 32'd4);
    chk("full_ready0", 32'(req_ready), 32'h0);
    hold[0] = 1'b0;
    #1;
    chk("full_still_full", 32'(req_ready), 32'h0);
    step(1);
    chk("full_count3", 32'(fifo_count), 32'd3);
    chk("full_5th_ready", 32'(req_ready), 32'h1);
    chk("full_issue", 32'(unit_job), 32'h011);
    step(1);
    chk("full_count_back4", 32'(fifo_count), 32'd4);
    hold[1] = 1'b0;
    wait_idle(150);

    // zero job
    do_reset();
    fq1.push_back('h00);
    step(1);
    chk("zero_ready", 32'(req_ready), 32'h2);
    step(1);
    chk("zero_count", 32'(fifo_count), 32'd0);
    step(1);
    chk("zero_job", 32'(unit_job), 32'h0);
    chk("zero_idle", {31'd0, idle}, 32'd1);

    // missing busy
    do_reset();
    nobusy = 2'b01;
    fq0.push_back('h33);
    step(3);
    chk("nobusy_issue", 32'(unit_job), 32'h033);
    step(1);
    chk("nobusy_err_lo", {31'd0, err}, 32'd0);
    step(1);
    chk("nobusy_err_hi", {31'd0, err}, 32'd1);
    nobusy = 2'b00;
    fq0.push_back('h34);
    step(1);
    chk("nobusy_err_once", {31'd0, err}, 32'd0);
    step(2);
    chk("nobusy_redispatch", 32'(unit_job), 32'h034);
    wait_idle(80);

    // async reset with unit 0 running and two jobs queued
    do_reset();
    hold = 2'b10;
    fq0.push_back('h21); fq0.push_back('h22); fq0.push_back('h23);
    step(3);
    chk("arst_issue", 32'(unit_job), 32'h021);
    step(1);
    chk("arst_queued", 32'(fifo_count), 32'd2);
    hold[0] = 1'b1;
    step(1);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_job", 32'(unit_job), 32'h0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_ready", 32'(req_ready), 32'h0);
    step(2);
    rst_n = 1'b1;
    fq0.push_back('h24);
    step(1);
    chk("arst_accept", 32'(req_ready), 32'h1);
    step(4);
    chk("arst_held_count", 32'(fifo_count), 32'd1);
    chk("arst_no_dispatch", 32'(unit_job), 32'h0);
    hold[0] = 1'b0;
    step(1);
    chk("arst_dispatch_u0", 32'(unit_job), 32'h024);
    hold = 2'b00;
    wait_idle(80);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/despachador_trabajos.md
Name: despachador_trabajos

Overview:
Job scheduler in front of a pool of consumidor-style vector work units: each unit has a 6-bit job input, where a nonzero value is a one-cycle start pulse, and a busy output. The block takes jobs from several requesters with valid/ready handshakes, arbitrates round-robin and buffers accepted jobs in a small FIFO. It then issues each job to the lowest-index free unit, tracking every unit with a small FSM so that no unit is double-booked.

Parameters:
NUM_REQ, 2, number of requesters
NUM_UNITS, 2, number of work units driven
JOB_W, 6, job code width; code 0 means "no job"
FIFO_DEPTH, 4, job buffer entries (power of 2, >=2)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  reset; asynchronous, active-low
req_valid_i  in  NUM_REQ  per-requester job valid
req_job_i  in  NUM_REQ*JOB_W  per-requester job code, requester r at bits [r*JOB_W +: JOB_W]
req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
unit_job_o  out  NUM_UNITS*JOB_W  job code to each unit, registered, 0 when not issuing
unit_busy_i  in  NUM_UNITS  busy flag from each unit
fifo_count_o  out  $clog2(FIFO_DEPTH+1)  jobs buffered
idle_o  out  1  FIFO empty and every unit tracker FREE with busy low
err_o  out  1  one-cycle pulse: a unit failed to raise busy after issue

Behaviour:
- Reset (rst_ni low, async): FIFO empty, rr pointer = 0, all trackers FREE, unit_job_o = 0, err_o = 0, req_ready_o = 0.
- Arbiter: combinational round-robin over req_valid_i, starting at the rr pointer. It grants only when the FIFO is not full; req_ready_o is high for the grantee only.
- Handshake: a job is accepted when valid & ready. The rr pointer then moves to grantee+1 (mod NUM_REQ). With no acceptance, the pointer holds.
- An accepted job with code 0 is consumed (ready high) but not enqueued.
- FIFO: no bypass. Push and pop in the same cycle are allowed at any occupancy except a push when full, which the arbiter prevents. Count is unchanged on push+pop. Pointers wrap mod FIFO_DEPTH.
- Dispatch: at most one job per cycle. The FIFO head goes to the lowest-index unit k whose tracker is FREE and whose unit_busy_i[k] is 0. On that edge the head is popped, unit_job_q[k] is loaded and tracker k enters ISSUE.
- Per-unit tracker states:
  FREE -> ISSUE on dispatch.
  ISSUE, one cycle, unit_job_o[k] = job -> WAIT_BUSY; unit_job_q[k] cleared to 0 at that edge.
  WAIT_BUSY, one cycle: busy high -> RUN; busy low -> FREE and pulse err_o.
  RUN: stay while busy high -> FREE on the first cycle busy is seen low.
- Timing against a 4-cycle unit: job accepted in cycle c; dispatch decision in c+1; unit_job_o nonzero in c+2 only; busy high c+3..c+6; tracker FREE from c+8; the next dispatch to the same unit is decided in c+8.
- err_o is the OR over units of the per-unit error pulse, registered, so it is high in the cycle after the WAIT_BUSY cycle.
- Reset mid-operation: trackers return to FREE, but a unit still reporting busy is not dispatched to until unit_busy_i drops. The units themselves have no reset.
- A valid requester that is not granted must hold its job. Starvation is bounded: a valid requester is granted within NUM_REQ acceptances.

Decomposition:
- Package despachador_pkg holds: JOB_W default, NO_JOB constant (0), and the unit_state_e enum {FREE, ISSUE, WAIT_BUSY, RUN}.
- Sub-module cola_trabajos: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/data/full/empty/count, and the same clk_i/rst_ni.
- Arbiter and trackers are inline, with trackers in a generate loop.

Test Plan:
- Single job: req0 valid with job 0x2A in cycle 1, unit model busy for 4 cycles -> ready0=1 in cycle 1; unit_job_o[0]=0x2A in cycle 3 only; unit 1 untouched; idle_o back to 1 in cycle 9.
- Fairness: req0 and req1 both continuously valid, jobs 0x01 and 0x02 -> acceptance order 0,1,0,1; unit 0 gets 0x01 and unit 1 gets 0x02.
- Full FIFO: both units held busy, push 5 jobs -> fifo_count_o reaches 4 and ready is 0 for the 5th; release unit 0 -> one pop, count 3, 5th job accepted on the next cycle.
- Zero job: req1 presents 0x00 -> ready1=1, fifo_count_o stays 0, unit_job_o stays 0.
- Missing busy: unit 0 model never asserts busy -> err_o pulses once, 2 cycles after the issue cycle; tracker returns FREE; the next job is redispatched to unit 0.
- Async reset mid-RUN: assert rst_ni low with unit 0 busy and 2 jobs queued -> outputs 0 and FIFO empty immediately; after release, no dispatch to unit 0 until unit_busy_i[0] falls.
